jtgng_ram_arb: RTL and testbench

- Access controller for a one-read-port / one-write-port dual RAM: owns the RAM's write port and read-address mux.
- After reset it zero-fills the whole RAM, then arbitrates the write port between a CPU writer and a DMA writer using round-robin.
- Time-shares the read port between a CPU reader (priority) and the video scanner (default owner).
- Sits between the CPU/DMA/video logic and the RAM instance in each game's memory subsystem.

---
 rtl/jtgng_ram_arb.sv | 94 +++++++++
 tb/tb_jtgng_ram_arb.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/jtgng_ram_arb.sv
// jtgng_ram_arb: zero-fills a dual-port RAM after reset, then round-robins its write port
// between CPU and DMA and shares its read port between CPU reads and the video scanner.
module jtgng_ram_arb #(
    parameter int DW = 8,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    output logic          busy,
    input  logic          cpu_wr_req,
    input  logic [AW-1:0] cpu_wr_addr,
    input  logic [DW-1:0] cpu_wr_data,
    output logic          cpu_wr_ack,
    input  logic          dma_req,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_data,
    output logic          dma_ack,
    input  logic          cpu_rd_req,
    input  logic [AW-1:0] cpu_rd_addr,
    output logic [DW-1:0] cpu_rd_data,
    output logic          cpu_rd_valid,
    input  logic [AW-1:0] vid_addr,
    output logic [DW-1:0] vid_data,
    output logic          vid_stall,
    output logic [AW-1:0] ram_wr_addr,
    output logic [DW-1:0] ram_data,
    output logic          ram_we,
    output logic [AW-1:0] ram_rd_addr,
    input  logic [DW-1:0] ram_q
);
    typedef enum logic {CLEAR, IDLE} state_t;
    state_t        state;
    logic [AW-1:0] cnt;
    logic          ptr;
    logic          rd_pend;
    logic          g_dma, g_cpu;
    // ptr holds the last granted source: 0 = CPU, 1 = DMA
    assign g_dma = dma_req && (!cpu_wr_req || !ptr);
    assign g_cpu = cpu_wr_req && !g_dma;
    assign ram_rd_addr = cpu_rd_req ? cpu_rd_addr : vid_addr;
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= CLEAR;
            cnt          <= '0;
            ptr          <= 1'b0;
            busy         <= 1'b1;
            ram_we       <= 1'b0;
            ram_wr_addr  <= '0;
            ram_data     <= '0;
            cpu_wr_ack   <= 1'b0;
            dma_ack      <= 1'b0;
            rd_pend      <= 1'b0;
            cpu_rd_valid <= 1'b0;
            cpu_rd_data  <= '0;
            vid_data     <= '0;
            vid_stall    <= 1'b0;
        end else begin
            cpu_wr_ack   <= cen && state == IDLE && g_cpu;
            dma_ack      <= cen && state == IDLE && g_dma;
            rd_pend      <= cpu_rd_req;
            cpu_rd_valid <= rd_pend;
            vid_stall    <= rd_pend;
            if (rd_pend) cpu_rd_data <= ram_q;
            else vid_data <= ram_q;
            if (cen) begin
                if (state == CLEAR) begin
                    // leave only once the write of the top address has been committed
                    if (ram_we && &ram_wr_addr) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        ram_we <= 1'b0;
                    end else begin
                        ram_we      <= 1'b1;
                        ram_wr_addr <= cnt;
                        ram_data    <= '0;
                        cnt         <= cnt + 1'b1;
                    end
                end else begin
                    ram_we <= g_cpu || g_dma;
                    if (g_dma) begin
                        ram_wr_addr <= dma_addr;
                        ram_data    <= dma_data;
                        ptr         <= 1'b1;
                    end else if (g_cpu) begin
                        ram_wr_addr <= cpu_wr_addr;
                        ram_data    <= cpu_wr_data;
                        ptr         <= 1'b0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_jtgng_ram_arb.sv
// tb_jtgng_ram_arb: directed bench for jtgng_ram_arb with AW=4 and a read-before-write RAM model.
module tb_jtgng_ram_arb;
    localparam int DW = 8;
    localparam int AW = 4;
    logic clk = 0, rst = 1, cen, busy;
    logic cpu_wr_req = 0, cpu_wr_ack, dma_req = 0, dma_ack;
    logic [AW-1:0] cpu_wr_addr = 0, dma_addr = 0, cpu_rd_addr = 0, vid_addr = 0;
    logic [DW-1:0] cpu_wr_data = 0, dma_data = 0, cpu_rd_data, vid_data, ram_data, ram_q;
    logic cpu_rd_req = 0, cpu_rd_valid, vid_stall, ram_we;
    logic [AW-1:0] ram_wr_addr, ram_rd_addr;
    logic [DW-1:0] mem [2**AW];
    logic div2 = 0, cen_ph = 0;
    int pass_cnt = 0, total = 0;

    jtgng_ram_arb #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst), .cen(cen), .busy(busy),
        .cpu_wr_req(cpu_wr_req), .cpu_wr_addr(cpu_wr_addr), .cpu_wr_data(cpu_wr_data), .cpu_wr_ack(cpu_wr_ack),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_data(dma_data), .dma_ack(dma_ack),
        .cpu_rd_req(cpu_rd_req), .cpu_rd_addr(cpu_rd_addr), .cpu_rd_data(cpu_rd_data), .cpu_rd_valid(cpu_rd_valid),
        .vid_addr(vid_addr), .vid_data(vid_data), .vid_stall(vid_stall),
        .ram_wr_addr(ram_wr_addr), .ram_data(ram_data), .ram_we(ram_we), .ram_rd_addr(ram_rd_addr), .ram_q(ram_q)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cen_ph <= ~cen_ph;
    assign cen = !div2 || cen_ph;

    initial begin
        for (int i = 0; i < 2**AW; i++) mem[i] = 8'hFF;
        ram_q = 0;
    end
    always @(posedge clk) begin
        ram_q <= mem[ram_rd_addr];
        if (cen && ram_we) mem[ram_wr_addr] <= ram_data;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Runs the clear after rst release; n = cen edges until busy falls, bad = malformed clear edges.
    task automatic run_clear(output int n, output int bad);
        logic c;
        n = 0;
        bad = 0;
        for (int t = 0; t < 200; t++) begin
            c = cen;
            tick();
            if (c) begin
                n++;
                if (n <= 2**AW && !(busy && ram_we && ram_wr_addr == AW'(n - 1) && ram_data == 0)) bad++;
            end
            if (cpu_wr_ack || dma_ack) bad++;
            if (!busy) break;
        end
    endtask

    task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        cpu_wr_req = 1; cpu_wr_addr = a; cpu_wr_data = d;
        tick();
        cpu_wr_req = 0;
        tick();
    endtask

    task automatic test_reset;
        int n, bad, nz;
        rst = 1; div2 = 1;
        tick(); tick();
        total++; if ({busy, ram_we, cpu_wr_ack, dma_ack, cpu_rd_valid, vid_stall} !== 6'b100000) $display("FAIL reset_flags got=%b want=100000", {busy, ram_we, cpu_wr_ack, dma_ack, cpu_rd_valid, vid_stall}); else pass_cnt++;
        total++; if ({ram_wr_addr, ram_data, cpu_rd_data, vid_data} !== '0) $display("FAIL reset_buses got=%h want=0", {ram_wr_addr, ram_data, cpu_rd_data, vid_data}); else pass_cnt++;
        rst = 0;
        run_clear(n, bad);
        total++; if (n !== 17) $display("FAIL clear_len got=%0d want=17", n); else pass_cnt++;
        total++; if (bad !== 0) $display("FAIL clear_seq got=%0d bad edges want=0", bad); else pass_cnt++;
        total++; if ({busy, ram_we} !== 2'b00) $display("FAIL clear_end got=%b want=00", {busy, ram_we}); else pass_cnt++;
        nz = 0;
        for (int i = 0; i < 2**AW; i++) if (mem[i] !== 0) nz++;
        total++; if (nz !== 0) $display("FAIL clear_dump got=%0d nonzero want=0", nz); else pass_cnt++;
        div2 = 0;
    endtask

    task automatic test_cpu_write;
        cpu_wr_req = 1; cpu_wr_addr = 5; cpu_wr_data = 8'hA5;
        tick();
        total++; if ({cpu_wr_ack, dma_ack, ram_we} !== 3'b101) $display("FAIL wr_grant got=%b want=101", {cpu_wr_ack, dma_ack, ram_we}); else pass_cnt++;
        total++; if ({ram_wr_addr, ram_data} !== {4'd5, 8'hA5}) $display("FAIL wr_bus got=%h want=5a5", {ram_wr_addr, ram_data}); else pass_cnt++;
        cpu_wr_req = 0;
        tick();
        total++; if ({cpu_wr_ack, ram_we} !== 2'b00) $display("FAIL wr_release got=%b want=00", {cpu_wr_ack, ram_we}); else pass_cnt++;
        total++; if (mem[5] !== 8'hA5) $display("FAIL wr_commit got=%h want=a5", mem[5]); else pass_cnt++;
    endtask

    task automatic test_round_robin;
        logic [1:0] exp [4];
        exp[0] = 2'b01; exp[1] = 2'b10; exp[2] = 2'b01; exp[3] = 2'b10;
        cpu_wr_req = 1; cpu_wr_addr = 13; cpu_wr_data = 8'h22;
        dma_req = 1; dma_addr = 12; dma_data = 8'h11;
        for (int g = 0; g < 4; g++) begin
            tick();
            if (g == 3) begin cpu_wr_req = 0; dma_req = 0; end
            total++; if ({cpu_wr_ack, dma_ack} !== exp[g]) $display("FAIL rr_grant%0d got={cpu,dma}=%b want=%b", g, {cpu_wr_ack, dma_ack}, exp[g]); else pass_cnt++;
        end
        tick();
        total++; if ({cpu_wr_ack, dma_ack} !== 2'b00) $display("FAIL rr_idle got=%b want=00", {cpu_wr_ack, dma_ack}); else pass_cnt++;
        total++; if ({mem[12], mem[13]} !== 16'h1122) $display("FAIL rr_data got=%h want=1122", {mem[12], mem[13]}); else pass_cnt++;
    endtask

    task automatic test_read_steal;
        cpu_write(7, 8'h77);
        vid_addr = 3;
        tick(); tick();
        total++; if ({vid_data, vid_stall} !== {8'h00, 1'b0}) $display("FAIL vid_idle got=%h want=000", {vid_data, vid_stall}); else pass_cnt++;
        vid_addr = 7; cpu_rd_req = 1; cpu_rd_addr = 5;
        tick();
        cpu_rd_req = 0;
        tick();
        total++; if ({cpu_rd_valid, vid_stall} !== 2'b11) $display("FAIL steal_flags got=%b want=11", {cpu_rd_valid, vid_stall}); else pass_cnt++;
        total++; if ({cpu_rd_data, vid_data} !== 16'hA500) $display("FAIL steal_data got=%h want=a500", {cpu_rd_data, vid_data}); else pass_cnt++;
        tick();
        total++; if ({cpu_rd_valid, vid_stall, vid_data} !== {2'b00, 8'h77}) $display("FAIL steal_resume got=%h want=077", {cpu_rd_valid, vid_stall, vid_data}); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        cpu_rd_req = 1; cpu_rd_addr = 12;
        tick();
        cpu_rd_addr = 13;
        tick();
        cpu_rd_req = 0;
        total++; if ({cpu_rd_valid, vid_stall, cpu_rd_data} !== {2'b11, 8'h11}) $display("FAIL b2b_first got=%h want=311", {cpu_rd_valid, vid_stall, cpu_rd_data}); else pass_cnt++;
        tick();
        total++; if ({cpu_rd_valid, vid_stall, cpu_rd_data} !== {2'b11, 8'h22}) $display("FAIL b2b_second got=%h want=322", {cpu_rd_valid, vid_stall, cpu_rd_data}); else pass_cnt++;
        tick();
        total++; if ({cpu_rd_valid, vid_stall} !== 2'b00) $display("FAIL b2b_end got=%b want=00", {cpu_rd_valid, vid_stall}); else pass_cnt++;
    endtask

    task automatic test_same_addr;
        cpu_wr_req = 1; cpu_wr_addr = 9; cpu_wr_data = 8'h3C;
        tick();
        cpu_wr_req = 0; cpu_rd_req = 1; cpu_rd_addr = 9;
        tick();
        tick();
        cpu_rd_req = 0;
        total++; if ({cpu_rd_valid, cpu_rd_data} !== {1'b1, 8'h00}) $display("FAIL rw_old got=%h want=100", {cpu_rd_valid, cpu_rd_data}); else pass_cnt++;
        tick();
        total++; if ({cpu_rd_valid, cpu_rd_data} !== {1'b1, 8'h3C}) $display("FAIL rw_new got=%h want=13c", {cpu_rd_valid, cpu_rd_data}); else pass_cnt++;
        tick();
    endtask

    task automatic test_reset_mid_clear;
        int n, bad, nz, t;
        div2 = 1; rst = 1;
        tick();
        rst = 0;
        t = 0;
        while (!(ram_we && ram_wr_addr == 6) && t < 100) begin tick(); t++; end
        total++; if (t >= 100) $display("FAIL mid_reach got=timeout want=addr6"); else pass_cnt++;
        dma_req = 1; dma_addr = 1; dma_data = 8'h55; rst = 1;
        tick();
        rst = 0;
        total++; if ({dma_ack, busy, ram_we, ram_wr_addr} !== {3'b010, 4'd0}) $display("FAIL mid_reset got=%b want=0100000", {dma_ack, busy, ram_we, ram_wr_addr}); else pass_cnt++;
        run_clear(n, bad);
        dma_req = 0;
        total++; if (n !== 17) $display("FAIL reclear_len got=%0d want=17", n); else pass_cnt++;
        total++; if (bad !== 0) $display("FAIL reclear_seq got=%0d bad edges want=0", bad); else pass_cnt++;
        nz = 0;
        for (int i = 0; i < 2**AW; i++) if (mem[i] !== 0) nz++;
        total++; if (nz !== 0) $display("FAIL reclear_dump got=%0d nonzero want=0", nz); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_cpu_write();
        test_round_robin();
        test_read_steal();
        test_back_to_back();
        test_same_addr();
        test_reset_mid_clear();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
